rd53_afe_to_fe_ctrl: RTL and testbench
======================================

RD53_AFE_TO_FE_CTRL -- requirements
Module: rd53_afe_to_fe_ctrl

Interface
REQ-001 Parameter AZ_S0_CYCLES, default 2: cycles of the auto-zero S0+S1 phase, legal range 1-15.
REQ-002 Parameter AZ_S1_CYCLES, default 4: cycles of the S1-only offset-store phase, legal range 1-15.
REQ-003 Parameter TOT_MAX, default 15: ToT saturation value, equal to 2**4-1.
REQ-004 CLK  in  1  single block clock (40 MHz bunch-crossing domain); all flops SHALL use its rising edge.
REQ-005 RESET_B  in  1  asynchronous, active-low reset.
REQ-006 POWER_DOWN_CFG  in  1  configuration bit that powers down the TO front end.
REQ-007 FAST_EN  in  1  configuration bit that enables the fast-mode delay-line path.
REQ-008 AZ_REQ  in  1  single-cycle auto-zero request.
REQ-009 S0, S1  out  1 each  auto-zero phase controls to the analog front end.
REQ-010 POWER_DOWN_TO  out  1  registered power-down to the analog front end.
REQ-011 DELAY_IN_TO  out  1  delay-line stimulus.
REQ-012 DELAY_OUT_TO  in  1  delay-line return.
REQ-013 VOUTP_TO, VOUTN_TO  in  1 each  differential latch output, asynchronous to CLK.
REQ-014 HIT_VALID  out  1  one-cycle strobe qualifying HIT_TOT and HIT_FINE.
REQ-015 HIT_TOT  out  4  time-over-threshold in CLK cycles.
REQ-016 HIT_FINE  out  1  sampled DELAY_OUT_TO for the hit (fast mode only, else 0).
REQ-017 AZ_BUSY  out  1  high while an auto-zero sequence is pending or running.

Function
REQ-018 Discriminator value SHALL be VOUTP_TO AND NOT VOUTN_TO; equal inputs SHALL count as 0.
REQ-019 The discriminator value SHALL pass through a 2-flop synchronizer; edge detection SHALL use the synchronized value and one further delayed copy.
REQ-020 Auto-zero FSM states: IDLE (S0=0,S1=0), AZ0 (S0=1,S1=1), AZ1 (S0=0,S1=1), GUARD (S0=0,S1=0); S0/S1 SHALL be registered outputs.
REQ-021 An AZ_REQ SHALL set a pending flag, and AZ_BUSY SHALL assert on the next cycle.
REQ-022 IDLE->AZ0 SHALL occur when pending=1 and no ToT measurement is active; the pending flag SHALL clear on entry to AZ0.
REQ-023 AZ0 SHALL last AZ_S0_CYCLES cycles, AZ1 AZ_S1_CYCLES cycles and GUARD 1 cycle, then the FSM SHALL return to IDLE; AZ_BUSY SHALL deassert on return to IDLE unless a new request is pending.
REQ-024 An AZ_REQ arriving while not in IDLE SHALL set pending and start one further sequence after return to IDLE; multiple requests SHALL merge into one.
REQ-025 Hit rising edges SHALL be ignored unless the FSM is in IDLE and the block is not powered down.
REQ-026 On an accepted rising edge the ToT counter SHALL load 1; each following cycle with synchronized disc=1 it SHALL increment, saturating at TOT_MAX.
REQ-027 On the falling edge HIT_VALID SHALL pulse for 1 cycle with HIT_TOT=counter, and the counter SHALL clear; latency from the synchronized falling edge to HIT_VALID SHALL be 1 cycle.
REQ-028 A ToT measurement active when AZ_REQ arrives SHALL complete and emit before AZ0 is entered.
REQ-029 With FAST_EN=1, DELAY_IN_TO SHALL be high for exactly 1 cycle at an accepted rising edge; DELAY_OUT_TO SHALL be registered on the following cycle into HIT_FINE, held until HIT_VALID. With FAST_EN=0, DELAY_IN_TO=0 and HIT_FINE=0.
REQ-030 POWER_DOWN_TO SHALL follow POWER_DOWN_CFG with 1 cycle of latency; while it is high the ToT measurement SHALL abort without HIT_VALID, the FSM SHALL go to IDLE, and pending SHALL clear.

Reset
REQ-031 While RESET_B=0: FSM=IDLE; S0=S1=0; POWER_DOWN_TO=1; DELAY_IN_TO=0; HIT_VALID=0; HIT_TOT=0; HIT_FINE=0; AZ_BUSY=0; synchronizers, counters and pending cleared.
REQ-032 A reset asserted mid-sequence or mid-hit SHALL discard all state; no HIT_VALID SHALL follow the deassertion of reset.

Structure
REQ-033 The FSM state enum, the 4-bit ToT width and TOT_MAX SHALL be defined in package rd53_afe_to_pkg.
REQ-034 The ToT counter plus edge logic SHALL be sub-module rd53_afe_to_tot_cnt; the FSM SHALL remain in the top level.
REQ-035 The block SHALL connect to the front end through the fe_control modport of the existing TO digital interface.

Verification
REQ-036 Disc high for 5 cycles, idle FSM -> one HIT_VALID, HIT_TOT=5, HIT_FINE=0.
REQ-037 Disc high for 40 cycles -> HIT_TOT=15 (saturated), with exactly one HIT_VALID.
REQ-038 AZ_REQ pulse with defaults -> S0=S1=1 for 2 cycles, S1 only for 4 cycles, 1 guard cycle; AZ_BUSY high throughout.
REQ-039 AZ_REQ during a 6-cycle hit -> hit emitted with TOT=6, then AZ0 starts; a hit during AZ produces no HIT_VALID.
REQ-040 FAST_EN=1, DELAY_OUT_TO=1 -> 1-cycle DELAY_IN_TO pulse at the hit edge, HIT_FINE=1 at HIT_VALID.
REQ-041 POWER_DOWN_CFG or RESET_B asserted mid-hit -> no HIT_VALID, all outputs at their reset values (POWER_DOWN_TO=1 after reset).

Source files
------------

// File: rtl/rd53_afe_to_pkg.sv
// Shared types and constants for the RD53 time-over-threshold (TO) front-end controller.
//   az_state_e  : auto-zero sequencer states
//   TOT_W       : ToT counter width
//   TOT_MAX     : ToT saturation value
//   tot_sat_inc : saturating ToT increment
package rd53_afe_to_pkg;

    localparam int unsigned TOT_W    = 4;
    localparam int unsigned TOT_MAX  = (2 ** TOT_W) - 1;
    localparam int unsigned AZ_CNT_W = 4;

    typedef logic [TOT_W-1:0] tot_t;

    // IDLE: S0=0 S1=0, AZ0: S0=1 S1=1, AZ1: S0=0 S1=1, GUARD: S0=0 S1=0
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AZ0   = 2'd1,
        AZ1   = 2'd2,
        GUARD = 2'd3
    } az_state_e;

    function automatic tot_t tot_sat_inc(input tot_t v, input tot_t max_v);
        return (v >= max_v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rd53_afe_to_if.sv
// TO digital interface between the controller and the analog front end.
//   s0, s1          : auto-zero phase controls (controller -> AFE)
//   power_down_to   : power-down (controller -> AFE)
//   delay_in_to     : delay-line stimulus (controller -> AFE)
//   delay_out_to    : delay-line return (AFE -> controller)
//   voutp_to/voutn_to : differential latch outputs, asynchronous (AFE -> controller)
interface rd53_afe_to_if;

    logic s0;
    logic s1;
    logic power_down_to;
    logic delay_in_to;
    logic delay_out_to;
    logic voutp_to;
    logic voutn_to;

    modport fe_control (
        output s0, s1, power_down_to, delay_in_to,
        input  delay_out_to, voutp_to, voutn_to
    );

    modport afe (
        input  s0, s1, power_down_to, delay_in_to,
        output delay_out_to, voutp_to, voutn_to
    );

endinterface

// File: rtl/rd53_afe_to_tot_cnt.sv
// Discriminator synchronizer, edge detection, ToT counter and fast-mode fine-time capture.
//   voutp/voutn   : raw latch outputs (asynchronous)
//   accept_c      : a rising edge may start a measurement this cycle
//   abort         : discard any measurement in progress (power-down)
//   fast_en       : enable delay-line stimulus and fine capture
//   delay_out     : delay-line return
//   tot_busy_c    : measurement active or starting this cycle
//   delay_in      : one-cycle delay-line stimulus at an accepted rising edge
//   hit_valid/hit_tot/hit_fine : one-cycle hit result, zero outside the strobe
module rd53_afe_to_tot_cnt #(
    parameter int unsigned TOT_MAX = rd53_afe_to_pkg::TOT_MAX
) (
    input  logic                            clk,
    input  logic                            reset_b,
    input  logic                            voutp,
    input  logic                            voutn,
    input  logic                            accept_c,
    input  logic                            abort,
    input  logic                            fast_en,
    input  logic                            delay_out,
    output logic                            tot_busy_c,
    output logic                            delay_in,
    output logic                            hit_valid,
    output logic [rd53_afe_to_pkg::TOT_W-1:0] hit_tot,
    output logic                            hit_fine
);
    import rd53_afe_to_pkg::*;

    logic sync1;
    logic disc;
    logic disc_d;
    logic active;
    logic fine_cap;
    tot_t cnt;

    logic rise_c;
    logic fall_c;
    logic rise_ok_c;
    logic fine_now_c;

    assign rise_c     = disc & ~disc_d;
    assign fall_c     = ~disc & disc_d;
    assign rise_ok_c  = rise_c & accept_c;
    assign tot_busy_c = active | rise_ok_c;
    // Delay-line return may land in the same cycle as a one-cycle hit's falling edge
    assign fine_now_c = delay_in ? delay_out : fine_cap;

    // Synchronizer, measurement and hit emission
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1     <= 1'b0;
            disc      <= 1'b0;
            disc_d    <= 1'b0;
            active    <= 1'b0;
            cnt       <= '0;
            fine_cap  <= 1'b0;
            delay_in  <= 1'b0;
            hit_valid <= 1'b0;
            hit_tot   <= '0;
            hit_fine  <= 1'b0;
        end else begin
            sync1     <= voutp & ~voutn;
            disc      <= sync1;
            disc_d    <= disc;
            delay_in  <= 1'b0;
            hit_valid <= 1'b0;
            hit_tot   <= '0;
            hit_fine  <= 1'b0;
            if (abort) begin
                active   <= 1'b0;
                cnt      <= '0;
                fine_cap <= 1'b0;
            end else if (active) begin
                if (fall_c) begin
                    hit_valid <= 1'b1;
                    hit_tot   <= cnt;
                    hit_fine  <= fast_en & fine_now_c;
                    active    <= 1'b0;
                    cnt       <= '0;
                    fine_cap  <= 1'b0;
                end else begin
                    cnt <= tot_sat_inc(cnt, TOT_W'(TOT_MAX));
                    if (delay_in) begin
                        fine_cap <= delay_out;
                    end
                end
            end else if (rise_ok_c) begin
                active   <= 1'b1;
                cnt      <= TOT_W'(1);
                delay_in <= fast_en;
                fine_cap <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rd53_afe_to_fe_ctrl.sv
// RD53 TO front-end controller: auto-zero sequencer, power-down and hit ToT measurement.
//   clk, reset_b   : block clock, asynchronous active-low reset
//   power_down_cfg : power down the front end (registered to power_down_to)
//   fast_en        : enable fast-mode delay-line path
//   az_req         : single-cycle auto-zero request
//   to_if          : TO digital interface, fe_control side
//   hit_valid/hit_tot/hit_fine : hit result strobe and payload
//   az_busy        : auto-zero pending or running
module rd53_afe_to_fe_ctrl #(
    parameter int unsigned AZ_S0_CYCLES = 2,
    parameter int unsigned AZ_S1_CYCLES = 4,
    parameter int unsigned TOT_MAX      = rd53_afe_to_pkg::TOT_MAX
) (
    input  logic                              clk,
    input  logic                              reset_b,
    input  logic                              power_down_cfg,
    input  logic                              fast_en,
    input  logic                              az_req,
    rd53_afe_to_if.fe_control                 to_if,
    output logic                              hit_valid,
    output logic [rd53_afe_to_pkg::TOT_W-1:0] hit_tot,
    output logic                              hit_fine,
    output logic                              az_busy
);
    import rd53_afe_to_pkg::*;

    az_state_e             state;
    az_state_e             state_nxt;
    logic [AZ_CNT_W-1:0]   az_cnt;
    logic [AZ_CNT_W-1:0]   az_cnt_nxt;
    logic                  pending;
    logic                  pending_nxt;
    logic                  pd;
    logic                  s0;
    logic                  s1;
    logic                  accept_c;
    logic                  tot_busy_c;

    assign to_if.s0            = s0;
    assign to_if.s1            = s1;
    assign to_if.power_down_to = pd;

    // Hits are only measured while the front end is idle and powered
    assign accept_c = (state == IDLE) && !pd;

    // Auto-zero next state; requests merge into a single pending flag
    always_comb begin
        state_nxt   = state;
        az_cnt_nxt  = az_cnt;
        pending_nxt = pending | az_req;
        if (pd) begin
            state_nxt   = IDLE;
            az_cnt_nxt  = '0;
            pending_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Wait for any ToT measurement (including one starting now) to finish
                    if (pending && !tot_busy_c) begin
                        state_nxt   = AZ0;
                        az_cnt_nxt  = '0;
                        pending_nxt = 1'b0;
                    end
                end
                AZ0: begin
                    if (az_cnt == AZ_CNT_W'(AZ_S0_CYCLES - 1)) begin
                        state_nxt  = AZ1;
                        az_cnt_nxt = '0;
                    end else begin
                        az_cnt_nxt = az_cnt + 1'b1;
                    end
                end
                AZ1: begin
                    if (az_cnt == AZ_CNT_W'(AZ_S1_CYCLES - 1)) begin
                        state_nxt  = GUARD;
                        az_cnt_nxt = '0;
                    end else begin
                        az_cnt_nxt = az_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    state_nxt  = IDLE;
                    az_cnt_nxt = '0;
                end
                default: begin
                    state_nxt  = IDLE;
                    az_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= IDLE;
            az_cnt  <= '0;
            pending <= 1'b0;
            pd      <= 1'b1;
            s0      <= 1'b0;
            s1      <= 1'b0;
            az_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            az_cnt  <= az_cnt_nxt;
            pending <= pending_nxt;
            pd      <= power_down_cfg;
            s0      <= (state_nxt == AZ0);
            s1      <= (state_nxt == AZ0) || (state_nxt == AZ1);
            az_busy <= pending_nxt || (state_nxt != IDLE);
        end
    end

    rd53_afe_to_tot_cnt #(
        .TOT_MAX (TOT_MAX)
    ) u_tot_cnt (
        .clk        (clk),
        .reset_b    (reset_b),
        .voutp      (to_if.voutp_to),
        .voutn      (to_if.voutn_to),
        .accept_c   (accept_c),
        .abort      (pd),
        .fast_en    (fast_en),
        .delay_out  (to_if.delay_out_to),
        .tot_busy_c (tot_busy_c),
        .delay_in   (to_if.delay_in_to),
        .hit_valid  (hit_valid),
        .hit_tot    (hit_tot),
        .hit_fine   (hit_fine)
    );

endmodule

// File: tb/tb_rd53_afe_to_fe_ctrl.sv
// Directed, scoreboard-checked bench for rd53_afe_to_fe_ctrl.
module tb_rd53_afe_to_fe_ctrl;

    typedef struct packed {
        logic [3:0] tot;
        logic       fine;
    } exp_hit_t;

    logic       clk;
    logic       reset_b;
    logic       power_down_cfg;
    logic       fast_en;
    logic       az_req;
    logic       hit_valid;
    logic [3:0] hit_tot;
    logic       hit_fine;
    logic       az_busy;

    rd53_afe_to_if to_if ();

    rd53_afe_to_fe_ctrl dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .power_down_cfg (power_down_cfg),
        .fast_en        (fast_en),
        .az_req         (az_req),
        .to_if          (to_if),
        .hit_valid      (hit_valid),
        .hit_tot        (hit_tot),
        .hit_fine       (hit_fine),
        .az_busy        (az_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_hit_t q[$];
    int checks = 0;
    int errors = 0;
    int di_cnt = 0;
    int s0_cnt = 0;
    int hits_seen = 0;
    logic s0_at_hit = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-cycle observation at the falling edge: counters and scoreboard
    task automatic observe();
        exp_hit_t e;
        if (to_if.delay_in_to === 1'b1) di_cnt++;
        if (to_if.s0 === 1'b1) s0_cnt++;
        if (hit_valid === 1'b1) begin
            hits_seen++;
            s0_at_hit = to_if.s0;
            if (q.size() == 0) begin
                check("unexpected_hit_valid", 32'(hit_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("hit_tot", 32'(hit_tot), 32'(e.tot));
                check("hit_fine", 32'(hit_fine), 32'(e.fine));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        check(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic drive_hit(input int len);
        to_if.voutp_to = 1'b1;
        repeat (len) tick();
        to_if.voutp_to = 1'b0;
        repeat (6) tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pd_to"}, 32'(to_if.power_down_to), 32'd1);
        check({tag, "_s0"}, 32'(to_if.s0), 32'd0);
        check({tag, "_s1"}, 32'(to_if.s1), 32'd0);
        check({tag, "_delay_in"}, 32'(to_if.delay_in_to), 32'd0);
        check({tag, "_hit_valid"}, 32'(hit_valid), 32'd0);
        check({tag, "_hit_tot"}, 32'(hit_tot), 32'd0);
        check({tag, "_hit_fine"}, 32'(hit_fine), 32'd0);
        check({tag, "_az_busy"}, 32'(az_busy), 32'd0);
    endtask

    initial begin
        int lens[7];
        int h0;
        logic [31:0] e_s0, e_s1;
        lens = '{1, 2, 5, 14, 15, 16, 40};

        reset_b           = 1'b0;
        power_down_cfg    = 1'b0;
        fast_en           = 1'b0;
        az_req            = 1'b0;
        to_if.voutp_to    = 1'b0;
        to_if.voutn_to    = 1'b0;
        to_if.delay_out_to = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        reset_b = 1'b1;
        #1;
        check("pd_after_release", 32'(to_if.power_down_to), 32'd1);
        @(posedge clk);
        #1;
        check("pd_follows_cfg", 32'(to_if.power_down_to), 32'd0);
        tick();

        // Slow-mode hits of several lengths, delay_out held high but ignored
        to_if.delay_out_to = 1'b1;
        di_cnt = 0;
        foreach (lens[k]) begin
            q.push_back('{tot: 4'((lens[k] > 15) ? 15 : lens[k]), fine: 1'b0});
            drive_hit(lens[k]);
            drain($sformatf("drain_len%0d", lens[k]));
        end
        check("slow_no_delay_in", 32'(di_cnt), 32'd0);

        // Equal latch outputs count as no hit
        to_if.voutn_to = 1'b1;
        drive_hit(5);
        to_if.voutn_to = 1'b0;
        repeat (3) tick();

        // Auto-zero sequence with default timing
        az_req = 1'b1;
        tick();
        az_req = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            e_s0 = (i >= 2 && i <= 3) ? 32'd1 : 32'd0;
            e_s1 = (i >= 2 && i <= 7) ? 32'd1 : 32'd0;
            check($sformatf("az_s0_c%0d", i), 32'(to_if.s0), e_s0);
            check($sformatf("az_s1_c%0d", i), 32'(to_if.s1), e_s1);
            check($sformatf("az_busy_c%0d", i), 32'(az_busy), (i <= 8) ? 32'd1 : 32'd0);
            tick();
        end

        // Request during a 6-cycle hit: hit emits first, then AZ0
        q.push_back('{tot: 4'd6, fine: 1'b0});
        to_if.voutp_to = 1'b1;
        repeat (2) tick();
        az_req = 1'b1;
        tick();
        az_req = 1'b0;
        repeat (3) tick();
        to_if.voutp_to = 1'b0;
        h0 = hits_seen;
        for (int i = 0; i < 12 && hits_seen == h0; i++) tick();
        check("hit_before_az_seen", 32'(hits_seen - h0), 32'd1);
        check("s0_low_at_hit", 32'(s0_at_hit), 32'd0);
        check("az0_after_hit_s0", 32'(to_if.s0), 32'd1);
        check("az0_after_hit_busy", 32'(az_busy), 32'd1);

        // Hit during auto-zero is ignored
        to_if.voutp_to = 1'b1;
        repeat (3) tick();
        to_if.voutp_to = 1'b0;
        for (int i = 0; i < 20 && az_busy !== 1'b0; i++) tick();
        check("az_done", 32'(az_busy), 32'd0);
        repeat (6) tick();
        drain("drain_az_hits");

        // Fast mode: one-cycle stimulus, fine time follows delay_out
        fast_en = 1'b1;
        to_if.delay_out_to = 1'b1;
        di_cnt = 0;
        q.push_back('{tot: 4'd4, fine: 1'b1});
        drive_hit(4);
        drain("drain_fast1");
        check("fast_delay_in_cycles", 32'(di_cnt), 32'd1);
        to_if.delay_out_to = 1'b0;
        di_cnt = 0;
        q.push_back('{tot: 4'd3, fine: 1'b0});
        drive_hit(3);
        drain("drain_fast0");
        check("fast_delay_in_cycles2", 32'(di_cnt), 32'd1);
        fast_en = 1'b0;

        // Power-down mid-hit aborts, requests while powered down are dropped
        to_if.voutp_to = 1'b1;
        repeat (4) tick();
        power_down_cfg = 1'b1;
        repeat (2) tick();
        az_req = 1'b1;
        tick();
        az_req = 1'b0;
        to_if.voutp_to = 1'b0;
        repeat (6) tick();
        check_quiet("pd_midhit");
        power_down_cfg = 1'b0;
        s0_cnt = 0;
        repeat (10) tick();
        check("pd_no_az_after", 32'(s0_cnt), 32'd0);
        check("pd_busy_after", 32'(az_busy), 32'd0);

        // Power-down mid auto-zero
        az_req = 1'b1;
        tick();
        az_req = 1'b0;
        repeat (3) tick();
        power_down_cfg = 1'b1;
        repeat (2) tick();
        check_quiet("pd_midaz");
        power_down_cfg = 1'b0;
        s0_cnt = 0;
        repeat (12) tick();
        check("pd_midaz_no_resume", 32'(s0_cnt), 32'd0);

        // Reset mid-hit
        to_if.voutp_to = 1'b1;
        repeat (4) tick();
        #2;
        reset_b = 1'b0;
        #1;
        check_quiet("rst_midhit");
        to_if.voutp_to = 1'b0;
        repeat (3) tick();
        reset_b = 1'b1;
        #1;
        check("rst_pd_after_release", 32'(to_if.power_down_to), 32'd1);
        repeat (8) tick();

        // Reset mid auto-zero
        az_req = 1'b1;
        tick();
        az_req = 1'b0;
        repeat (3) tick();
        reset_b = 1'b0;
        #1;
        check_quiet("rst_midaz");
        tick();
        reset_b = 1'b1;
        s0_cnt = 0;
        repeat (12) tick();
        check("rst_midaz_no_resume", 32'(s0_cnt), 32'd0);

        // Recovery after reset
        q.push_back('{tot: 4'd2, fine: 1'b0});
        drive_hit(2);
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
